// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and types for the instruction fetch slice.
//   LINE_WORDS / WORD_BYTES / LINE_BYTES describe the cache line geometry,
//   fetch_state_t is the fetch FSM state encoding used by ifetch_queue.
package ifetch_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned OFF_W      = 2;  // word offset within a line
  localparam int unsigned NWORD_W    = 3;  // holds 1..LINE_WORDS

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  // Number of words written when a line is accepted at word offset off.
  function automatic logic [NWORD_W-1:0] words_from_offset(input logic [OFF_W-1:0] off);
    return NWORD_W'(LINE_WORDS) - NWORD_W'(off);
  endfunction

endpackage

// File: rtl/instruction_queue.sv
// instruction_queue: circular buffer of {PC, instruction} entries.
//   Accepts up to LINE_WORDS words per cycle (words wr_offset..LINE_WORDS-1 of
//   wr_line, tagged wr_pc, wr_pc+4, ...) and presents one head entry per cycle.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   flush          discard all entries; same-cycle write and pop are ignored
//   wr_en          write the selected words of wr_line
//   wr_offset      first line word to write
//   wr_line        cache line, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_pc          PC of the first written word
//   pop_ready      consumer takes the head when head_valid
//   head_inst/pc   head entry, zero when empty
//   head_valid     queue non-empty
//   count          occupied entries
module instruction_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                wr_en,
  input  logic [OFF_W-1:0]                    wr_offset,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0]    wr_line,
  input  logic [ADDRESS_WIDTH-1:0]            wr_pc,
  input  logic                                pop_ready,
  output logic [DATA_WIDTH-1:0]               head_inst,
  output logic [ADDRESS_WIDTH-1:0]            head_pc,
  output logic                                head_valid,
  output logic [$clog2(QUEUE_DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0]    mem_inst [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_pc   [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]    line_word [LINE_WORDS];

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [NWORD_W-1:0] wr_n;
  logic               pop;
  logic               do_write;

  // Split the line into words for indexed selection.
  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      line_word[k] = wr_line[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wr_n       = words_from_offset(wr_offset);
  assign head_valid = (count != '0);
  assign pop        = head_valid && pop_ready && !flush;
  assign do_write   = wr_en && !flush;

  assign head_inst  = head_valid ? mem_inst[rd_ptr] : '0;
  assign head_pc    = head_valid ? mem_pc[rd_ptr]   : '0;

  // Entry storage: no reset needed, occupancy is tracked by count.
  // The masked write may straddle the wrap point; pointer arithmetic wraps.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (NWORD_W'(i) < wr_n) begin
          mem_inst[PTR_W'(wr_ptr + PTR_W'(i))] <= line_word[OFF_W'(wr_offset + OFF_W'(i))];
          mem_pc[PTR_W'(wr_ptr + PTR_W'(i))]   <= wr_pc + ADDRESS_WIDTH'(i * WORD_BYTES);
        end
      end
    end
  end

  // Pointers and occupancy. Flush empties the queue by catching rd_ptr up.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(wr_n);
      end
      count <= count + (do_write ? CNT_W'(wr_n) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch initiator.
//   Owns the fetch PC, drives the (combinational) instruction cache, captures
//   returned lines into instruction_queue and flushes on branch redirect.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   PC_out             line-aligned fetch address to the cache
//   Rd_en              cache read enable
//   Abort              cache abort, asserted with Branch_valid
//   Cache_Dout         returned line, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Cache_Dout_valid   Cache_Dout holds a valid line
//   Branch_valid       redirect request, highest priority
//   Branch_target      word-aligned redirect PC
//   Inst_out, Inst_PC  queue head instruction and its PC (zero when empty)
//   Inst_valid         queue non-empty
//   Dispatch_ready     consumer pops the head when Inst_valid
//   Queue_count        occupied queue entries
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned               DATA_WIDTH    = 32,
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               QUEUE_DEPTH   = 16,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic [ADDRESS_WIDTH-1:0]          PC_out,
  output logic                              Rd_en,
  output logic                              Abort,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0]  Cache_Dout,
  input  logic                              Cache_Dout_valid,
  input  logic                              Branch_valid,
  input  logic [ADDRESS_WIDTH-1:0]          Branch_target,
  output logic [DATA_WIDTH-1:0]             Inst_out,
  output logic [ADDRESS_WIDTH-1:0]          Inst_PC,
  output logic                              Inst_valid,
  input  logic                              Dispatch_ready,
  output logic [$clog2(QUEUE_DEPTH):0]      Queue_count
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] SPACE_LIMIT = CNT_W'(QUEUE_DEPTH - LINE_WORDS);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] line_base;
  logic [OFF_W-1:0]         word_off;
  logic                     space_ok;
  logic                     rd_en_int;
  logic                     accept;

  logic [DATA_WIDTH-1:0]    q_inst;
  logic [ADDRESS_WIDTH-1:0] q_pc;
  logic                     q_valid;
  logic [CNT_W-1:0]         q_count;

  assign line_base = {fetch_pc[ADDRESS_WIDTH-1:4], 4'b0000};
  assign word_off  = fetch_pc[3:2];

  // Space is judged on the occupancy before any same-cycle pop.
  assign space_ok  = (q_count <= SPACE_LIMIT);
  assign rd_en_int = (state == FETCH) && space_ok && !Branch_valid;
  assign accept    = rd_en_int && Cache_Dout_valid;

  // Cache-side outputs, forced to zero while reset is held.
  assign PC_out = reset ? '0 : line_base;
  assign Rd_en  = !reset && rd_en_int;
  assign Abort  = !reset && Branch_valid;

  // Decode-side outputs.
  assign Inst_out    = reset ? '0 : q_inst;
  assign Inst_PC     = reset ? '0 : q_pc;
  assign Inst_valid  = !reset && q_valid;
  assign Queue_count = reset ? '0 : q_count;

  // Fetch FSM and fetch PC; a redirect overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
    end else if (Branch_valid) begin
      state    <= REDIRECT;
      fetch_pc <= Branch_target;
    end else begin
      case (state)
        FETCH: begin
          if (!space_ok) begin
            state <= STALL;
          end else if (accept) begin
            fetch_pc <= line_base + ADDRESS_WIDTH'(LINE_BYTES);
          end
        end
        STALL: begin
          if (space_ok) begin
            state <= FETCH;
          end
        end
        REDIRECT: begin
          state <= FETCH;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  instruction_queue #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .QUEUE_DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (Branch_valid),
    .wr_en      (accept),
    .wr_offset  (word_off),
    .wr_line    (Cache_Dout),
    .wr_pc      (fetch_pc),
    .pop_ready  (Dispatch_ready),
    .head_inst  (q_inst),
    .head_pc    (q_pc),
    .head_valid (q_valid),
    .count      (q_count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: self-checking bench for ifetch_queue.
//   Directed table, hand-written corner sequences and a random run, all
//   checked against a queue-based behavioural model of the fetch unit.
module tb_ifetch_queue;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] RPC   = 32'h100;

  logic          clk;
  logic          reset;
  logic [31:0]   pc_out;
  logic          rd_en;
  logic          abort;
  logic [127:0]  cache_dout;
  logic          cache_valid;
  logic          branch_valid;
  logic [31:0]   branch_target;
  logic [31:0]   inst_out;
  logic [31:0]   inst_pc;
  logic          inst_valid;
  logic          dispatch_ready;
  logic [4:0]    queue_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  localparam int M_FETCH = 0, M_STALL = 1, M_REDIR = 2;
  logic [31:0] m_q [$];
  logic [31:0] m_pc;
  int          m_mode;

  // Last sampled DUT values for the directed sequences
  logic        s_rd, s_abort;
  logic [31:0] s_pc_out, s_inst_pc;
  logic [4:0]  s_count;

  ifetch_queue #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .QUEUE_DEPTH   (DEPTH),
    .RESET_PC      (RPC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PC_out           (pc_out),
    .Rd_en            (rd_en),
    .Abort            (abort),
    .Cache_Dout       (cache_dout),
    .Cache_Dout_valid (cache_valid),
    .Branch_valid     (branch_valid),
    .Branch_target    (branch_target),
    .Inst_out         (inst_out),
    .Inst_PC          (inst_pc),
    .Inst_valid       (inst_valid),
    .Dispatch_ready   (dispatch_ready),
    .Queue_count      (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction content is a fixed scramble of its address.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Combinational cache: returns the line at PC_out.
  always_comb begin
    cache_dout = '0;
    for (int k = 0; k < 4; k++) begin
      cache_dout[k*32 +: 32] = inst_of(pc_out + 32'(4 * k));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = RPC;
    m_mode = M_FETCH;
  endtask

  // Hold reset for two edges, check all outputs are zero, then release.
  task automatic apply_reset();
    reset = 1'b1;
    branch_valid = 1'b0; branch_target = '0;
    dispatch_ready = 1'b0; cache_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_out", pc_out, 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst_out", inst_out, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_count", 32'(queue_count), 0);
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, compare DUT against model, advance model.
  task automatic step(input logic bv, input logic [31:0] tgt, input logic rdy, input logic cv);
    int          sz;
    int          n;
    logic        sp;
    logic        e_rd;
    logic [31:0] e_head;
    branch_valid = bv; branch_target = tgt; dispatch_ready = rdy; cache_valid = cv;
    #1;
    sz     = m_q.size();
    sp     = (DEPTH - sz) >= 4;
    e_rd   = (m_mode == M_FETCH) && sp && !bv;
    e_head = (sz != 0) ? m_q[0] : 32'h0;
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("abort", 32'(abort), 32'(bv));
    chk("pc_out", pc_out, m_pc & ~32'hF);
    chk("count", 32'(queue_count), 32'(sz));
    chk("inst_valid", 32'(inst_valid), 32'(sz != 0));
    chk("inst_pc", inst_pc, e_head);
    chk("inst_out", inst_out, (sz != 0) ? inst_of(e_head) : 32'h0);
    s_rd = rd_en; s_abort = abort; s_pc_out = pc_out; s_inst_pc = inst_pc; s_count = queue_count;
    if (bv) begin
      m_q.delete();
      m_pc   = tgt;
      m_mode = M_REDIR;
    end else begin
      if (sz != 0 && rdy) void'(m_q.pop_front());
      if (e_rd && cv) begin
        n = 4 - int'(m_pc[3:2]);
        for (int i = 0; i < n; i++) m_q.push_back(m_pc + 32'(4 * i));
        m_pc = (m_pc & ~32'hF) + 32'd16;
      end
      case (m_mode)
        M_FETCH: if (!sp) m_mode = M_STALL;
        M_STALL: if (sp)  m_mode = M_FETCH;
        default: m_mode = M_FETCH;
      endcase
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        bv;
    logic [31:0] tgt;
    logic        rdy;
    logic        cv;
    logic        e_rd;
    logic        e_abort;
    logic [31:0] e_pc_out;
    logic [4:0]  e_count;
    logic [31:0] e_inst_pc;
  } row_t;

  row_t tbl [13];

  initial begin
    logic [31:0] tgt;

    // Directed table: stream from reset, stall, then redirect to 0x208.
    tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 5'd0,  32'h0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h110, 5'd4,  32'h100};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h120, 5'd7,  32'h104};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h130, 5'd10, 32'h108};
    tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h140, 5'd13, 32'h10C};
    tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h140, 5'd12, 32'h110};
    tbl[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h140, 5'd11, 32'h114};
    tbl[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h150, 5'd14, 32'h118};
    tbl[8]  = '{1'b1, 32'h208, 1'b1, 1'b1, 1'b0, 1'b1, 32'h150, 5'd13, 32'h11C};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 5'd0,  32'h0};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 5'd0,  32'h0};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h210, 5'd2,  32'h208};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h220, 5'd5,  32'h20C};

    apply_reset();
    for (int r = 0; r < 13; r++) begin
      step(tbl[r].bv, tbl[r].tgt, tbl[r].rdy, tbl[r].cv);
      chk($sformatf("tbl%0d_rd_en", r), 32'(s_rd), 32'(tbl[r].e_rd));
      chk($sformatf("tbl%0d_abort", r), 32'(s_abort), 32'(tbl[r].e_abort));
      chk($sformatf("tbl%0d_pc_out", r), s_pc_out, tbl[r].e_pc_out);
      chk($sformatf("tbl%0d_count", r), 32'(s_count), 32'(tbl[r].e_count));
      chk($sformatf("tbl%0d_inst_pc", r), s_inst_pc, tbl[r].e_inst_pc);
    end

    // Fill to 16 with no dispatch, stall, resume only once 4 slots free.
    apply_reset();
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_full_count", 32'(s_count), 32'd16);
    chk("stall_full_rd", 32'(s_rd), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_one_pop_rd", 32'(s_rd), 32'd0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_after4_rd", 32'(s_rd), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("resume_rd", 32'(s_rd), 32'd1);
    chk("resume_count", 32'(s_count), 32'd12);

    // Cache not ready for 3 cycles: request held, queue untouched.
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("miss_rd", 32'(s_rd), 32'd1);
      chk("miss_pc_out", s_pc_out, 32'h110);
      chk("miss_count", 32'(s_count), 32'd4);
    end
    // Branch with pop and valid line in the same cycle.
    step(1'b1, 32'h400, 1'b1, 1'b1);
    chk("coinc_abort", 32'(s_abort), 32'd1);
    chk("coinc_rd", 32'(s_rd), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("coinc_count", 32'(s_count), 32'd0);
    chk("coinc_pc_out", s_pc_out, 32'h400);

    // Write straddling the queue wrap point (write pointer 14).
    apply_reset();
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h1008, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("wrap_inst_pc%0d", k), s_inst_pc, 32'h1008 + 32'(4 * k));
    end

    // Random traffic against the model.
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1) == 0) tgt = 32'($urandom_range(0, 255)) << 2;
      else                           tgt = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 19) == 0, tgt,
           $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
